// File: rtl/colour_seeker.sv
// Drives button pulses into the lights selector until its RGB bus shows the
// requested colour code, then reports done (or err on a bad request / timeout).
module colour_seeker #(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        bench_clk,
    input  logic        bench_rst,
    input  logic        req_valid,
    input  logic [2:0]  req_colour,
    output logic        req_ready,
    input  logic [23:0] light,
    output logic        button,
    output logic [2:0]  cur_colour,
    output logic [2:0]  presses,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    logic             ready_q;
    logic             button_q;
    logic             done_q;
    logic             err_q;
    logic [2:0]       presses_q;
    logic [2:0]       target_q;
    logic [2:0]       expect_q;
    logic [2:0]       cur_colour_q;
    logic [2:0]       colour_d;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [2:0] next_code(input logic [2:0] c);
        return (c == 3'd6) ? 3'd1 : c + 3'd1;
    endfunction

    function automatic logic legal_code(input logic [2:0] c);
        return (c != 3'd0) && (c != 3'd7);
    endfunction

    always_comb begin
        colour_d = 3'd0;
        case (light)
            24'h0000FF: colour_d = 3'd1;
            24'h00FF00: colour_d = 3'd2;
            24'h00FFFF: colour_d = 3'd3;
            24'hFF0000: colour_d = 3'd4;
            24'hFF00FF: colour_d = 3'd5;
            24'hFFFF00: colour_d = 3'd6;
            24'hFFFFFF: colour_d = 3'd7;
            default:    colour_d = 3'd0;
        endcase
    end

    always_ff @(posedge bench_clk or posedge bench_rst) begin
        if (bench_rst) cur_colour_q <= '0;
        else           cur_colour_q <= colour_d;
    end

    // ready_q mirrors "state is IDLE" but stays low during and right at reset release
    always_ff @(posedge bench_clk or posedge bench_rst) begin
        if (bench_rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            button_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            presses_q <= '0;
            target_q  <= '0;
            expect_q  <= '0;
            cnt_q     <= '0;
        end else begin
            button_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        target_q  <= req_colour;
                        presses_q <= '0;
                        if (!legal_code(req_colour) || !legal_code(cur_colour_q)) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (req_colour == cur_colour_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_PRESS;
                            button_q <= 1'b1;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_PRESS: begin
                    expect_q  <= next_code((presses_q == 3'd0) ? cur_colour_q : expect_q);
                    presses_q <= presses_q + 3'd1;
                    cnt_q     <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cur_colour_q == expect_q) begin
                        if (expect_q == target_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_PRESS;
                            button_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign button     = button_q;
    assign done       = done_q;
    assign err        = err_q;
    assign presses    = presses_q;
    assign cur_colour = cur_colour_q;

endmodule
